// File: rtl/fp16_pkg.sv
// Shared fp16 field widths, constants and the accumulator FSM state type.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fp16_add_comb.sv
// Combinational fp16 adder: hidden-one always assumed, truncating, with no
// subnormal/Inf/NaN handling. Only the 0x0000 pattern is treated as zero.
module fp16_add_comb
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [EXP_W-1:0] ea, eb, e_big, shamt;
  logic [MAN_W:0]   fa, fb, f_big, f_sml, pos, neg, mag;
  logic             s_big, s_sml, res_sign, found;
  logic [11:0]      sum12, diff12;
  logic [MAN_W-1:0] man;
  logic [5:0]       e6;
  logic [3:0]       lz;
  logic [15:0]      normal;

  always_comb begin
    ea       = a[14:10];
    eb       = b[14:10];
    fa       = {1'b1, a[9:0]};
    fb       = {1'b1, b[9:0]};
    e_big    = ea;
    shamt    = '0;
    f_big    = fa;
    f_sml    = fb;
    s_big    = a[15];
    s_sml    = b[15];
    sum12    = '0;
    diff12   = '0;
    pos      = '0;
    neg      = '0;
    mag      = '0;
    lz       = '0;
    found    = 1'b0;
    man      = '0;
    e6       = '0;
    res_sign = 1'b0;
    normal   = FP16_ZERO;
    sum      = FP16_ZERO;

    // Align the smaller-exponent fraction to the larger exponent.
    if (ea >= eb) begin
      e_big = ea;
      shamt = ea - eb;
      f_big = fa;
      f_sml = fb >> shamt;
      s_big = a[15];
      s_sml = b[15];
    end else begin
      e_big = eb;
      shamt = eb - ea;
      f_big = fb;
      f_sml = fa >> shamt;
      s_big = b[15];
      s_sml = a[15];
    end

    if (s_big == s_sml) begin
      sum12    = {1'b0, f_big} + {1'b0, f_sml};
      res_sign = s_big;
      if (sum12[11]) begin
        man = sum12[10:1];
        e6  = {1'b0, e_big} + 6'd1;
      end else begin
        man = sum12[9:0];
        e6  = {1'b0, e_big};
      end
    end else begin
      pos      = s_big ? f_sml : f_big;
      neg      = s_big ? f_big : f_sml;
      diff12   = {1'b0, pos} - {1'b0, neg};
      res_sign = diff12[11];
      mag      = diff12[11] ? (~diff12[10:0] + 11'd1) : diff12[10:0];
      for (int i = 10; i >= 0; i--) begin
        if (mag[i] && !found) begin
          lz    = 4'(10 - i);
          found = 1'b1;
        end
      end
      man = 10'(mag << lz);
      e6  = {1'b0, e_big} - {2'b00, lz};
    end

    // Bit 5 of the widened exponent flags underflow below 0 or overflow past 31.
    normal = e6[5] ? FP16_ZERO : {res_sign, e6[4:0], man};

    if (a == FP16_ZERO)
      sum = b;
    else if (b == FP16_ZERO)
      sum = a;
    else if ((a[14:0] == b[14:0]) && (a[15] != b[15]))
      sum = FP16_ZERO;
    else
      sum = normal;
  end

endmodule

// File: rtl/fp16_accum_stream.sv
// Sums LEN fp16 terms onto a bias and hands one result per window downstream.
// Handshakes: a transfer happens on a cycle where valid && ready; ready/valid are decoded from state only.
module fp16_accum_stream
  import fp16_pkg::*;
#(
  parameter int LEN   = 9,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_e           state, state_d;
  logic [15:0]      acc, acc_d, add_sum;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             accept;

  fp16_add_comb u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_sum)
  );

  assign accept = (state == ACCUM) && in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= FP16_ZERO;
      cnt   <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_d   = bias;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt + 1'b1;
          if (cnt == LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = acc;

endmodule
